// File: rtl/fp_div_pkg.sv
// Shared types, flag positions and IEEE-754 field helpers for the sequential FP divider.
// Helpers take zero-extended fields so one definition serves any EXP_W/MAN_W.
package fp_div_pkg;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_e;

  localparam int FLG_W         = 5;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam int MAX_EXP_W = 16;
  localparam int MAX_MAN_W = 64;
  localparam int MAX_W     = 1 + MAX_EXP_W + MAX_MAN_W;

  function automatic logic [MAX_EXP_W-1:0] exp_ones(input int exp_w);
    return {MAX_EXP_W{1'b1}} >> (MAX_EXP_W - exp_w);
  endfunction

  function automatic logic fp_is_nan(input logic [MAX_EXP_W-1:0] e,
                                     input logic [MAX_MAN_W-1:0] f, input int exp_w);
    return (e == exp_ones(exp_w)) && (f != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [MAX_EXP_W-1:0] e,
                                     input logic [MAX_MAN_W-1:0] f, input int exp_w);
    return (e == exp_ones(exp_w)) && (f == '0);
  endfunction

  function automatic logic fp_is_zero(input logic [MAX_EXP_W-1:0] e,
                                      input logic [MAX_MAN_W-1:0] f);
    return (e == '0) && (f == '0);
  endfunction

  // Positive quiet NaN: all-ones exponent, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = (MAX_W'(exp_ones(exp_w)) << man_w) | (MAX_W'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq; slave is the divider side.
interface fp_div_seq_if #(parameter int DATAWIDTH = 32);
  logic                 valid_i;
  logic                 ready_o;
  logic [DATAWIDTH-1:0] data_iA;
  logic [DATAWIDTH-1:0] data_iB;
  logic                 valid_o;
  logic                 ready_i;
  logic [DATAWIDTH-1:0] data_o;
  logic [4:0]           flags_o;

  modport slave  (input  valid_i, data_iA, data_iB, ready_i,
                  output ready_o, valid_o, data_o, flags_o);
  modport master (output valid_i, data_iA, data_iB, ready_i,
                  input  ready_o, valid_o, data_o, flags_o);
endinterface

// File: rtl/fp_div_mant_iter.sv
// Radix-2 restoring divider for {1,fA}/{1,fB}: one quotient bit per cycle, MAN_W+3 bits total.
// last_o is high during the cycle whose edge writes the final quotient bit.
module fp_div_mant_iter #(
  parameter int MAN_W = 23
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start_i,
  input  logic [MAN_W:0]   dividend_i,
  input  logic [MAN_W:0]   divisor_i,
  output logic             last_o,
  output logic [MAN_W+2:0] quot_o,
  output logic [MAN_W+1:0] rem_o
);
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic [CW-1:0] LAST = CW'(MAN_W + 2);

  logic [MAN_W+1:0] rem_q, rem_sel;
  logic [MAN_W:0]   div_q;
  logic [MAN_W+2:0] quot_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, ge;

  assign ge      = rem_q >= {1'b0, div_q};
  assign rem_sel = ge ? (rem_q - {1'b0, div_q}) : rem_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= {1'b0, dividend_i};
      div_q  <= divisor_i;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // rem_sel < divisor < 2**(MAN_W+1), so its top bit is always clear before the shift.
      rem_q  <= {rem_sel[MAN_W:0], 1'b0};
      quot_q <= {quot_q[MAN_W+1:0], ge};
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  assign last_o = busy_q && (cnt_q == LAST);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 style divider: special-case decode, iterative mantissa divide,
// RNE rounding and exception flags behind valid/ready handshakes, one op in flight.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         Clk,
  input logic         Reset_n,
  fp_div_seq_if.slave bus
);
  localparam int DATAWIDTH = 1 + EXP_W + MAN_W;
  localparam int BIAS      = 2**(EXP_W-1) - 1;
  localparam int EW        = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [DATAWIDTH-1:0]   data_q, data_d;
  logic [FLG_W-1:0]       flags_q, flags_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign_in, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic signed [EW-1:0] e_in;

  // Denormal operands are flushed to zero before classification.
  assign ea      = bus.data_iA[DATAWIDTH-2 -: EXP_W];
  assign eb      = bus.data_iB[DATAWIDTH-2 -: EXP_W];
  assign fa      = (ea == '0) ? '0 : bus.data_iA[MAN_W-1:0];
  assign fb      = (eb == '0) ? '0 : bus.data_iB[MAN_W-1:0];
  assign sign_in = bus.data_iA[DATAWIDTH-1] ^ bus.data_iB[DATAWIDTH-1];
  assign nan_a   = fp_is_nan(MAX_EXP_W'(ea), MAX_MAN_W'(fa), EXP_W);
  assign nan_b   = fp_is_nan(MAX_EXP_W'(eb), MAX_MAN_W'(fb), EXP_W);
  assign inf_a   = fp_is_inf(MAX_EXP_W'(ea), MAX_MAN_W'(fa), EXP_W);
  assign inf_b   = fp_is_inf(MAX_EXP_W'(eb), MAX_MAN_W'(fb), EXP_W);
  assign zero_a  = fp_is_zero(MAX_EXP_W'(ea), MAX_MAN_W'(fa));
  assign zero_b  = fp_is_zero(MAX_EXP_W'(eb), MAX_MAN_W'(fb));
  assign e_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

  logic                 is_special;
  logic [DATAWIDTH-1:0] spec_data;
  logic [FLG_W-1:0]     spec_flags;

  always_comb begin
    is_special = 1'b1;
    spec_data  = '0;
    spec_flags = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_data               = DATAWIDTH'(fp_qnan(EXP_W, MAN_W));
      spec_flags[FLG_INVALID] = 1'b1;
    end else if (inf_a) begin
      spec_data = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_b) begin
      spec_data               = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags[FLG_DIVZERO] = 1'b1;
    end else if (zero_a || inf_b) begin
      spec_data = {sign_in, {(DATAWIDTH-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  logic             iter_start, iter_last;
  logic [MAN_W+2:0] quot;
  logic [MAN_W+1:0] rem;

  fp_div_mant_iter #(.MAN_W(MAN_W)) u_iter (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start_i    (iter_start),
    .dividend_i ({1'b1, fa}),
    .divisor_i  ({1'b1, fb}),
    .last_o     (iter_last),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  logic [MAN_W+2:0]     norm;
  logic signed [EW-1:0] e_norm, e_rnd;
  logic                 guard, sticky, round_up;
  logic [MAN_W+1:0]     mant_rnd;
  logic [MAN_W-1:0]     frac_rnd;
  logic [DATAWIDTH-1:0] rnd_data;
  logic [FLG_W-1:0]     rnd_flags;

  always_comb begin
    norm      = quot[MAN_W+2] ? quot : {quot[MAN_W+1:0], 1'b0};
    e_norm    = quot[MAN_W+2] ? exp_q : exp_q - E_ONE;
    guard     = norm[1];
    sticky    = norm[0] | (rem != '0);
    round_up  = guard & (sticky | norm[2]);
    mant_rnd  = {1'b0, norm[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, round_up};
    e_rnd     = e_norm;
    frac_rnd  = mant_rnd[MAN_W-1:0];
    if (mant_rnd[MAN_W+1]) begin
      e_rnd    = e_norm + E_ONE;
      frac_rnd = '0;
    end
    rnd_flags = '0;
    rnd_flags[FLG_INEXACT] = guard | sticky;
    rnd_data  = {sign_q, e_rnd[EXP_W-1:0], frac_rnd};
    if (e_rnd >= E_MAX) begin
      rnd_data                 = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags[FLG_OVERFLOW]  = 1'b1;
      rnd_flags[FLG_INEXACT]   = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      rnd_data                 = {sign_q, {(DATAWIDTH-1){1'b0}}};
      rnd_flags[FLG_UNDERFLOW] = 1'b1;
      rnd_flags[FLG_INEXACT]   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    data_d     = data_q;
    flags_d    = flags_q;
    iter_start = 1'b0;
    unique case (state_q)
      IDLE: if (bus.valid_i) begin
        sign_d = sign_in;
        exp_d  = e_in;
        if (is_special) begin
          data_d  = spec_data;
          flags_d = spec_flags;
          state_d = DONE;
        end else begin
          iter_start = 1'b1;
          state_d    = DIV;
        end
      end
      DIV:  if (iter_last) state_d = RND;
      RND: begin
        data_d  = rnd_data;
        flags_d = rnd_flags;
        state_d = DONE;
      end
      DONE: if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.data_o  = data_q;
  assign bus.flags_o = flags_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq at default widths: integer-arithmetic reference model, a per-cycle
// monitor comparing outputs/handshakes/latency, directed vectors plus randomized operands.
module tb_fp_div_seq;
  logic Clk;
  logic Reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  fp_div_seq_if #(.DATAWIDTH(32)) bus ();

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Exact quotient of the significands from integer division, then round-to-nearest-even.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [4:0] f, output bit special);
    logic s;
    int ea, eb, e;
    logic [22:0] fa, fb;
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b, g, st;
    longint unsigned ma, mb, num, q, rm, sig;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = (ea == 0) ? 23'h0 : a[22:0];
    fb = (eb == 0) ? 23'h0 : b[22:0];
    nan_a = (ea == 255) && (fa != 0);  inf_a = (ea == 255) && (fa == 0);  z_a = (ea == 0);
    nan_b = (eb == 255) && (fb != 0);  inf_b = (eb == 255) && (fb == 0);  z_b = (eb == 0);
    special = 1'b1;
    f = 5'b00000;
    r = 32'h0;
    if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) begin
      r = 32'h7FC00000; f = 5'b10000;
    end else if (inf_a) begin
      r = {s, 31'h7F800000};
    end else if (z_b) begin
      r = {s, 31'h7F800000}; f = 5'b01000;
    end else if (z_a || inf_b) begin
      r = {s, 31'h0};
    end else begin
      special = 1'b0;
      ma  = 64'h800000 | 64'(fa);
      mb  = 64'h800000 | 64'(fb);
      num = ma << 25;
      q   = num / mb;
      rm  = num % mb;
      e   = ea - eb + 127;
      if (ma >= mb) begin
        sig = q >> 2; g = q[1]; st = q[0] | (rm != 0);
      end else begin
        sig = q >> 1; g = q[0]; st = (rm != 0); e = e - 1;
      end
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig == 64'h1000000) begin sig = 64'h800000; e = e + 1; end
      if (e >= 255) begin
        r = {s, 31'h7F800000}; f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 5'b00011;
      end else begin
        r = {s, 8'(e), sig[22:0]}; f = {4'b0000, g | st};
      end
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
    bit          special;
    int          hs;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every falling edge checks handshakes, held results and latency against the model.
  initial begin
    bit   seen_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset_n) begin
        exp_q.delete();
        seen_valid = 1'b0;
      end else begin
        chk("ready_o", 32'(bus.ready_o), 32'(exp_q.size() == 0));
        if (exp_q.size() == 0) begin
          chk("valid_o_idle", 32'(bus.valid_o), 32'(0));
        end else if (bus.valid_o) begin
          chk("data_o", bus.data_o, exp_q[0].data);
          chk("flags_o", 32'(bus.flags_o), 32'(exp_q[0].flags));
          if (!seen_valid) begin
            chk("latency", 32'(cyc - exp_q[0].hs), exp_q[0].special ? 32'd1 : 32'd28);
            seen_valid = 1'b1;
          end
          if (bus.ready_i) begin
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
        if (bus.valid_i && bus.ready_o) begin
          model(bus.data_iA, bus.data_iB, e.data, e.flags, e.special);
          e.hs = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic do_issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.ready_o && n < 100) begin @(posedge Clk); #1; n++; end
    if (n >= 100) chk("issue_timeout", 32'(0), 32'(1));
    bus.data_iA = a;
    bus.data_iB = b;
    bus.valid_i = 1'b1;
    @(posedge Clk); #1;
    bus.valid_i = 1'b0;
    bus.data_iA = $urandom;
    bus.data_iB = $urandom;
  endtask

  task automatic wait_result(input int hold, output logic [31:0] d, output logic [4:0] f);
    int n = 0;
    bus.ready_i = (hold == 0);
    while (!bus.valid_o && n < 100) begin @(posedge Clk); #1; n++; end
    if (n >= 100) chk("result_timeout", 32'(0), 32'(1));
    d = bus.data_o;
    f = bus.flags_o;
    repeat (hold) begin @(posedge Clk); #1; end
    bus.ready_i = 1'b1;
    @(posedge Clk); #1;
    bus.ready_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    int          k  = int'($urandom_range(0, 11));
    logic        s  = 1'($urandom);
    logic [22:0] fr = 23'($urandom);
    logic [7:0]  e;
    case (k)
      0:       begin e = 8'h00; fr = '0; end
      1:       begin e = 8'hFF; fr = '0; end
      2:       begin e = 8'hFF; fr = fr | 23'h1; end
      3:       begin e = 8'h00; fr = fr | 23'h1; end
      4:       e = 8'($urandom_range(1, 254));
      5:       e = 8'($urandom_range(1, 20));
      6:       e = 8'($urandom_range(235, 254));
      7:       begin e = 8'($urandom_range(110, 140)); fr = '1; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, fr};
  endfunction

  localparam int ND = 10;
  logic [31:0] va [ND] = '{32'h40C9999A, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h00000000,
                           32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC00001, 32'h3F800000};
  logic [31:0] vb [ND] = '{32'h40066666, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                           32'h7F800000, 32'h3E800000, 32'h4B000000, 32'h3F800000, 32'h80000000};
  logic [31:0] vr [ND] = '{32'h40400001, 32'h3EAAAAAB, 32'hC0400000, 32'h7F800000, 32'h7FC00000,
                           32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
  logic [4:0]  vf [ND] = '{5'b00001, 5'b00001, 5'b00000, 5'b01000, 5'b10000,
                           5'b10000, 5'b00101, 5'b00011, 5'b10000, 5'b01000};

  initial begin
    logic [31:0] d, mr, held;
    logic [4:0]  f, mf, held_f;
    bit          sp;
    int          n;
    Reset_n     = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_iA = '0;
    bus.data_iB = '0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready_o", 32'(bus.ready_o), 32'(1));
    chk("rst_valid_o", 32'(bus.valid_o), 32'(0));
    chk("rst_data_o", bus.data_o, 32'h0);
    chk("rst_flags_o", 32'(bus.flags_o), 32'(0));
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    for (int i = 0; i < ND; i++) begin
      model(va[i], vb[i], mr, mf, sp);
      chk($sformatf("model_data_%0d", i), mr, vr[i]);
      chk($sformatf("model_flags_%0d", i), 32'(mf), 32'(vf[i]));
      do_issue(va[i], vb[i]);
      wait_result(0, d, f);
      chk($sformatf("dir_data_%0d", i), d, vr[i]);
      chk($sformatf("dir_flags_%0d", i), 32'(f), 32'(vf[i]));
    end

    // Backpressure: result held, ready_o low, a stray valid_i pulse is ignored.
    do_issue(32'h3F800000, 32'h40400000);
    n = 0;
    while (!bus.valid_o && n < 100) begin @(posedge Clk); #1; n++; end
    if (n >= 100) chk("bp_timeout", 32'(0), 32'(1));
    held   = bus.data_o;
    held_f = bus.flags_o;
    chk("bp_first", held, 32'h3EAAAAAB);
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = (i == 3);
      bus.data_iA = 32'h40C00000;
      bus.data_iB = 32'h40000000;
      @(posedge Clk); #1;
      chk("bp_ready_o", 32'(bus.ready_o), 32'(0));
      chk("bp_valid_o", 32'(bus.valid_o), 32'(1));
      chk("bp_data_hold", bus.data_o, held);
      chk("bp_flags_hold", 32'(bus.flags_o), 32'(held_f));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge Clk); #1;
    bus.ready_i = 1'b0;
    chk("bp_idle_ready", 32'(bus.ready_o), 32'(1));
    chk("bp_idle_valid", 32'(bus.valid_o), 32'(0));

    // Reset in the middle of the mantissa iteration, then a fresh operation.
    do_issue(32'h40C9999A, 32'h40066666);
    repeat (9) begin @(posedge Clk); #1; end
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("mid_rst_ready", 32'(bus.ready_o), 32'(1));
    chk("mid_rst_valid", 32'(bus.valid_o), 32'(0));
    chk("mid_rst_data", bus.data_o, 32'h0);
    do_issue(32'h40C00000, 32'h40000000);
    wait_result(0, d, f);
    chk("post_rst_data", d, 32'h40400000);
    chk("post_rst_flags", 32'(f), 32'(0));

    for (int i = 0; i < 60; i++) begin
      do_issue(rand_op(), rand_op());
      wait_result(int'($urandom_range(0, 3)), d, f);
    end

    repeat (3) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point divider: data_o = data_iA / data_iB.
- Successor to the single-precision combinational divider. Adds generic exponent/mantissa widths, a radix-2 restoring mantissa iterator, round-to-nearest-even, exception flags and valid/ready handshakes on both sides.
- Sits between operand producers and the FP result bus; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.
- DATAWIDTH, 1+EXP_W+MAN_W (32), operand/result width (derived; not overridden independently).
- BIAS, 2**(EXP_W-1)-1, exponent bias (derived).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  block can accept operands.
- data_iA  in  DATAWIDTH  dividend.
- data_iB  in  DATAWIDTH  divisor.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- data_o  out  DATAWIDTH  quotient.
- flags_o  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; valid with valid_o.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - state=IDLE, ready_o=1, valid_o=0, data_o=0, flags_o=0.
  - Reset aborts any operation in progress; there is no output for the aborted operation.
- States:
  - IDLE: ready_o=1. A handshake (valid_i & ready_o) latches both operands and decodes them.
    - Special operand -> DONE on the next edge.
    - Otherwise -> DIV, iteration counter=0.
  - DIV: one quotient bit per cycle for MAN_W+3 cycles, then -> RND.
  - RND: one cycle for normalise, round and exponent check, then -> DONE.
  - DONE: valid_o=1; data_o and flags_o are held stable.
    - valid_o & ready_i -> IDLE.
    - ready_o stays 0 until IDLE; no accept in the same cycle as the output handshake.
- Latency, valid_i edge to valid_o: normal operands 1+(MAN_W+3)+1 = 28 cycles at defaults; specials 1 cycle.
- Operand decode:
  - Sign = sA^sB.
  - Denormal inputs (exp=0, frac!=0) are flushed to zero before classification.
- Special-case priority, highest first:
  1. Either operand NaN -> canonical qNaN (0, all-ones exp, frac MSB=1), invalid=1.
  2. 0/0 or inf/inf -> qNaN, invalid=1.
  3. inf/x -> signed inf.
  4. x/0 -> signed inf, div_by_zero=1.
  5. 0/x or x/inf -> signed zero.
- Mantissa division:
  - Divide {1,fA} by {1,fB} with a restoring divider.
  - Partial remainder width MAN_W+2; quotient register MAN_W+3 bits (1 integer bit + MAN_W+2 fraction bits).
  - Result exponent, computed signed with EXP_W+2 bits: e = eA - eB + BIAS.
- Normalise:
  - If quotient MSB=0: shift left 1 and e=e-1.
  - guard = bit below LSB; sticky = OR of lower bits | (remainder!=0).
- Rounding, RNE:
  - Round up if guard & (sticky | LSB).
  - Mantissa carry-out -> e=e+1, fraction=0.
  - inexact = guard|sticky.
- Exponent range:
  - e >= 2**EXP_W-1 after rounding -> signed inf, overflow=1, inexact=1.
  - e <= 0 -> signed zero, underflow=1, inexact=1 (no denormal outputs).
- valid_i while busy is ignored; the upstream must hold its operands until ready_o.

Decomposition:
- fp_div_pkg holds:
  - state enum {IDLE, DIV, RND, DONE};
  - flag bit index constants FLG_INVALID..FLG_INEXACT;
  - helper functions fp_is_nan/fp_is_inf/fp_is_zero parameterised by EXP_W/MAN_W;
  - canonical qNaN builder.
- One sub-module, fp_div_mant_iter:
  - restoring divider datapath (remainder, quotient shift register, counter);
  - start/done interface;
  - width MAN_W.
- FSM, exception decode and rounding stay in fp_div_seq.

Test Plan:
- 0x40C9999A / 0x40066666, ready_i=1 -> valid_o after 28 cycles; data_o=0x40400001, flags_o=00001 (inexact).
- 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, inexact=1. Also 0xC0C00000 / 0x40000000 -> 0xC0400000, flags_o=0.
- Special cases, each with latency 1:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, invalid.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000, invalid.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow|inexact.
  - 0x00800000 / 0x4B000000 -> 0x00000000, underflow|inexact.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> data_o/flags_o stable and ready_o=0; a second valid_i pulse is ignored. Release ready_i -> IDLE next cycle.
- Reset mid-operation: assert Reset_n=0 at iteration 10 -> next cycle ready_o=1, valid_o=0. A fresh 6.0/2.0 then gives 0x40400000.
